// File: rtl/lcd_i2c_ctrl.sv
// HD44780 character-LCD controller driving a PCF8574 I2C backpack in 4-bit mode.
// Runs the power-up init list on its own. After that it accepts one command or
// data byte per valid/ready handshake. Each byte becomes one I2C write
// transaction, followed by the LCD execution wait.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// PWRUP     | waiting for LCD supply to settle after reset
// INIT_TX   | sending one item of the init list
// INIT_WAIT | LCD execution wait after an init item
// IDLE      | ready for a request
// TX        | sending the accepted request byte
// WAIT      | LCD execution wait after a request
module lcd_i2c_ctrl #(
    parameter int         CLK_HZ          = 50_000_000,
    parameter int         I2C_HZ          = 100_000,
    parameter logic [6:0] I2C_ADDR        = 7'h27,
    parameter int         POWERUP_CYCLES  = 2_500_000,
    parameter int         CMD_WAIT_CYCLES = 2500,
    parameter int         CLR_WAIT_CYCLES = 100_000,
    parameter bit         BACKLIGHT       = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       busy,
    output logic       nack_err,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam int QTR  = CLK_HZ / (4 * I2C_HZ);
    localparam int MAX1 = (POWERUP_CYCLES > CLR_WAIT_CYCLES) ? POWERUP_CYCLES : CLR_WAIT_CYCLES;
    localparam int MAX2 = (MAX1 > CMD_WAIT_CYCLES) ? MAX1 : CMD_WAIT_CYCLES;
    localparam int MAXC = (MAX2 > QTR) ? MAX2 : QTR;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [1:0] SEG_START = 2'd0;
    localparam logic [1:0] SEG_BYTE  = 2'd1;
    localparam logic [1:0] SEG_STOP  = 2'd2;

    typedef enum logic [2:0] {PWRUP, INIT_TX, INIT_WAIT, IDLE, TX, WAIT} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   qcnt;
    logic [1:0]      phase;
    logic [1:0]      seg;
    logic [3:0]      bit_idx;
    logic [2:0]      byte_idx;
    logic [2:0]      init_idx;
    logic            single;
    logic            rs_q;
    logic [7:0]      data_q;
    logic            ack_nack;
    logic            sda_r;

    logic            tx_active, wait_active, cnt_zero, qtick, tx_done, enter_tx, long_wait;
    logic [2:0]      last_byte, idx_nxt;
    logic [3:0]      nibble;
    logic [7:0]      cur_byte, init_byte;

    assign tx_active   = (state == INIT_TX) || (state == TX);
    assign wait_active = (state == PWRUP) || (state == INIT_WAIT) || (state == WAIT);
    assign cnt_zero    = (cnt == '0);
    assign qtick       = (qcnt == '0);
    assign tx_done     = tx_active && (seg == SEG_STOP) && (phase == 2'd3) && qtick;
    assign enter_tx    = ((state_nxt == INIT_TX) || (state_nxt == TX)) && !tx_active;
    assign last_byte   = single ? 3'd2 : 3'd4;
    assign long_wait   = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));
    assign idx_nxt     = (state == PWRUP) ? 3'd0 : init_idx + 3'd1;

    // Odd data bytes carry EN=1 and even ones EN=0, so each nibble is strobed
    // by the byte pair. Single-nibble items hold their nibble in the high half.
    assign nibble   = (byte_idx <= 3'd2) ? data_q[7:4] : data_q[3:0];
    assign cur_byte = (byte_idx == 3'd0) ? {I2C_ADDR, 1'b0}
                                         : {nibble, BACKLIGHT, byte_idx[0], 1'b0, rs_q};

    // The START segment begins at phase 2. SDA therefore falls on the first
    // cycle of a transaction. SCL is low in phases 0-1 and released in phases 2-3.
    assign scl_oe = tx_active && ((seg == SEG_START) ? (phase == 2'd3) : !phase[1]);
    assign sda_oe = sda_r;

    // Init list: the first four items are single 8-bit-mode nibbles. The rest are full bytes.
    always_comb begin
        case (idx_nxt)
            3'd0, 3'd1, 3'd2: init_byte = 8'h30;
            3'd3:             init_byte = 8'h20;
            3'd4:             init_byte = 8'h28;
            3'd5:             init_byte = 8'h0C;
            3'd6:             init_byte = 8'h06;
            default:          init_byte = 8'h01;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= PWRUP;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        case (state)
            PWRUP:     if (cnt_zero) state_nxt = INIT_TX;
            INIT_TX:   if (tx_done) state_nxt = INIT_WAIT;
            INIT_WAIT: if (cnt_zero) state_nxt = (init_idx == 3'd7) ? IDLE : INIT_TX;
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_nxt = TX;
            end
            TX:        if (tx_done) state_nxt = WAIT;
            WAIT:      if (cnt_zero) state_nxt = IDLE;
            default:   state_nxt = PWRUP;
        endcase
    end

    // Delay counters, transaction loading and the bit-level I2C engine
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= CW'(POWERUP_CYCLES - 1);
            qcnt      <= '0;
            phase     <= 2'd0;
            seg       <= SEG_START;
            bit_idx   <= 4'd0;
            byte_idx  <= 3'd0;
            init_idx  <= 3'd0;
            single    <= 1'b0;
            rs_q      <= 1'b0;
            data_q    <= 8'h00;
            ack_nack  <= 1'b0;
            sda_r     <= 1'b0;
            init_done <= 1'b0;
            nack_err  <= 1'b0;
        end else begin
            if (wait_active && !cnt_zero) cnt <= cnt - 1'b1;

            if (enter_tx) begin
                seg      <= SEG_START;
                phase    <= 2'd2;
                qcnt     <= CW'(QTR - 1);
                sda_r    <= 1'b1;
                bit_idx  <= 4'd0;
                byte_idx <= 3'd0;
                ack_nack <= 1'b0;
                if (state_nxt == TX) begin
                    rs_q   <= req_rs;
                    data_q <= req_data;
                    single <= 1'b0;
                end else begin
                    rs_q     <= 1'b0;
                    data_q   <= init_byte;
                    single   <= (idx_nxt < 3'd4);
                    init_idx <= idx_nxt;
                end
            end else if (tx_active) begin
                if (!qtick) begin
                    qcnt <= qcnt - 1'b1;
                end else begin
                    qcnt  <= CW'(QTR - 1);
                    phase <= phase + 2'd1;
                    case (seg)
                        SEG_START: if (phase == 2'd3) begin
                            seg   <= SEG_BYTE;
                            phase <= 2'd0;
                        end
                        SEG_BYTE: begin
                            // SDA moves one quarter after SCL falls, which gives slave hold time.
                            if (phase == 2'd0)
                                sda_r <= (bit_idx == 4'd8) ? 1'b0 : ~cur_byte[3'd7 - bit_idx[2:0]];
                            if (phase == 2'd2 && bit_idx == 4'd8) begin
                                ack_nack <= sda_i;
                                if (sda_i) nack_err <= 1'b1;
                            end
                            if (phase == 2'd3) begin
                                if (bit_idx != 4'd8) begin
                                    bit_idx <= bit_idx + 4'd1;
                                end else begin
                                    bit_idx <= 4'd0;
                                    if (ack_nack || byte_idx == last_byte) seg <= SEG_STOP;
                                    else byte_idx <= byte_idx + 3'd1;
                                end
                            end
                        end
                        default: begin
                            if (phase == 2'd0) sda_r <= 1'b1;
                            if (phase == 2'd2) sda_r <= 1'b0;
                        end
                    endcase
                end
            end

            if (tx_done)
                cnt <= long_wait ? CW'(CLR_WAIT_CYCLES - 1) : CW'(CMD_WAIT_CYCLES - 1);
            if (state == INIT_WAIT && state_nxt == IDLE) init_done <= 1'b1;
        end
    end

endmodule
